// File: rtl/estagio_busca_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// default width / reset PC.
package pacote_busca;

  localparam int WIDTH_PADRAO = 32;

  // The PC adder resets its output to 1, so the fetch PC has to start at 0.
  localparam logic [WIDTH_PADRAO-1:0] RESET_PC_PADRAO = '0;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    VALIDO = 2'd2
  } estado_t;

endpackage

// File: rtl/estagio_busca_registro_desvio.sv
// Redirect latch: picks jump over branch and remembers a redirect that arrives
// while a fetch cannot be cancelled yet. A later redirect overwrites the target.
module registro_desvio #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             limpa_i,
  output logic             desvio_agora_o,
  output logic             desvio_ativo_o,
  output logic             pendente_o,
  output logic [WIDTH-1:0] alvo_o
);

  logic             pendente_q, pendente_d;
  logic [WIDTH-1:0] alvo_q, alvo_d;
  logic [WIDTH-1:0] alvo_agora;

  assign desvio_agora_o = jump | branch_taken;
  assign alvo_agora     = jump ? jump_target : branch_target;

  always_comb begin
    pendente_d = pendente_q;
    alvo_d     = alvo_q;
    if (limpa_i) begin
      pendente_d = 1'b0;
    end else if (desvio_agora_o) begin
      pendente_d = 1'b1;
      alvo_d     = alvo_agora;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pendente_q <= 1'b0;
      alvo_q     <= '0;
    end else begin
      pendente_q <= pendente_d;
      alvo_q     <= alvo_d;
    end
  end

  // A redirect presented this cycle is newer than anything latched.
  assign desvio_ativo_o = desvio_agora_o | pendente_q;
  assign alvo_o         = desvio_agora_o ? alvo_agora : alvo_q;
  assign pendente_o     = pendente_q;

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, fetches via a req/ready handshake and
// holds each instruction for decode; redirects squash in-flight or held words.
module estagio_busca
  import pacote_busca::*;
#(
  parameter int             WIDTH    = WIDTH_PADRAO,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_mais_um,
  output logic [WIDTH-1:0] pc_atual,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output estado_t          estado_dbg_o,
  output logic             pendente_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid (imem_req /
  // if_valid) and ready (imem_ready / if_ready) are both high; valid never
  // drops before its transfer, except that a redirect withdraws if_valid.

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ifpc_q, ifpc_d;

  logic             limpa;
  logic             desvio_agora;
  logic             desvio_ativo;
  logic [WIDTH-1:0] alvo;

  registro_desvio #(.WIDTH(WIDTH)) u_desvio (
    .clock          (clock),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .limpa_i        (limpa),
    .desvio_agora_o (desvio_agora),
    .desvio_ativo_o (desvio_ativo),
    .pendente_o     (pendente_dbg_o),
    .alvo_o         (alvo)
  );

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    limpa    = 1'b0;
    imem_req = 1'b0;
    if_valid = 1'b0;
    case (estado_q)
      INICIO: begin
        estado_d = BUSCA;
      end
      BUSCA: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (desvio_ativo) begin
            // The word in flight belongs to the old path: drop it and refetch.
            pc_d  = alvo;
            limpa = 1'b1;
          end else begin
            instr_d  = imem_data;
            ifpc_d   = pc_q;
            estado_d = VALIDO;
          end
        end
      end
      VALIDO: begin
        if_valid = 1'b1;
        if (desvio_agora) begin
          pc_d     = alvo;
          limpa    = 1'b1;
          estado_d = BUSCA;
        end else if (if_ready) begin
          pc_d     = pc_mais_um;
          estado_d = BUSCA;
        end
      end
      default: begin
        estado_d = INICIO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ifpc_q   <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
    end
  end

  assign pc_atual     = pc_q;
  assign imem_addr    = pc_q;
  assign if_instr     = instr_q;
  assign if_pc        = ifpc_q;
  assign estado_dbg_o = estado_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Bench for estagio_busca: directed scenarios followed by random traffic,
// checked against a transaction-level model of the fetch stream.
module tb_estagio_busca;
  import pacote_busca::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_mais_um;
  logic [31:0] pc_atual;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  estado_t     estado_dbg;
  logic        pendente_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];

  // Reference model of the fetch stream
  bit          m_started;
  bit          m_held;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  logic [31:0] m_instr;

  estagio_busca #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_mais_um     (pc_mais_um),
    .pc_atual       (pc_atual),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .estado_dbg_o   (estado_dbg),
    .pendente_dbg_o (pendente_dbg)
  );

  // ---------------- clock / environment ----------------
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_000A;
  endfunction

  assign imem_data = mem_fn(imem_addr);

  // PC adder: registered PC + 1, resets to 1.
  always @(posedge clock or posedge reset) begin
    if (reset) pc_mais_um <= 32'd1;
    else       pc_mais_um <= pc_atual + 32'd1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_held    = 0;
    m_pend    = 0;
    m_pc      = 32'h0;
    m_ptgt    = 32'h0;
    m_instr   = 32'h0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_started && !m_held));
    chk("if_valid", 32'(if_valid), 32'(m_held));
    chk("pc_atual", pc_atual, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    if (m_held) begin
      chk("if_instr_held", if_instr, m_instr);
      chk("if_pc_held", if_pc, m_pc);
    end
  endtask

  // One clock of the abstract fetch stream: what the stage must do with the
  // inputs presented during this cycle.
  task automatic model_step(input bit rdy, input bit irdy, input bit br, input bit jp,
                            input logic [31:0] bt, input logic [31:0] jt);
    bit          redir;
    logic [31:0] tgt;
    redir = jp | br;
    tgt   = jp ? jt : bt;
    if (!m_started) begin
      m_started = 1;
      if (redir) begin
        m_pend = 1;
        m_ptgt = tgt;
      end
    end else if (!m_held) begin
      if (rdy) begin
        if (redir) begin
          m_pc   = tgt;
          m_pend = 0;
        end else if (m_pend) begin
          m_pc   = m_ptgt;
          m_pend = 0;
        end else begin
          m_held  = 1;
          m_instr = mem_fn(m_pc);
        end
      end else if (redir) begin
        m_pend = 1;
        m_ptgt = tgt;
      end
    end else begin
      if (redir) begin
        m_held = 0;
        m_pc   = tgt;
      end else if (irdy) begin
        exp_q.push_back({m_pc, m_instr});
        m_held = 0;
        m_pc   = m_pc + 32'd1;
      end
    end
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic cycle(input bit rdy, input bit irdy, input bit br, input bit jp,
                       input logic [31:0] bt, input logic [31:0] jt);
    check_outputs();
    imem_ready    = rdy;
    if_ready      = irdy;
    branch_taken  = br;
    jump          = jp;
    branch_target = bt;
    jump_target   = jt;
    model_step(rdy, irdy, br, jp, bt, jt);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_pc_atual", pc_atual, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_state", 32'(estado_dbg), 32'(INICIO));
    chk("rst_pending", 32'(pendente_dbg), 32'h0);
  endtask

  // Reset asserted between edges; a stale imem_ready is left high across it.
  task automatic reset_mid();
    reset        = 1'b1;
    imem_ready   = 1'b1;
    branch_taken = 1'b0;
    jump         = 1'b0;
    if_ready     = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hFFFF_FFFE;
      2:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && if_valid && if_ready && !jump && !branch_taken) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_handoff: got pc %h instr %h expected none at %0t",
                 if_pc, if_instr, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("handoff_pc", if_pc, e[63:32]);
        chk("handoff_instr", if_instr, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b0;

    // Reset and first fetch: data 0xA at address 0
    cycle(0, 0, 0, 0, 0, 0);                 // INICIO
    cycle(1, 0, 0, 0, 0, 0);                 // BUSCA @0, ready
    chk("first_instr", if_instr, 32'h0000_000A);
    // Decode stall for 5 cycles
    repeat (5) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);                 // handshake
    chk("addr_after_first", imem_addr, 32'h1);
    cycle(1, 0, 0, 0, 0, 0);                 // fetch @1
    // Jump in VALIDO beats a simultaneous if_ready
    cycle(0, 1, 0, 1, 0, 32'h40);
    chk("jump_addr", imem_addr, 32'h40);
    // Branch during wait-stated fetch, ready 3 cycles later (data discarded)
    cycle(0, 0, 1, 0, 32'h20, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("branch_pending_addr", imem_addr, 32'h20);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);                 // fetch @0x21
    // Jump and branch together
    cycle(0, 0, 1, 1, 32'h90, 32'h80);
    chk("jump_priority", pc_atual, 32'h80);
    cycle(1, 0, 0, 0, 0, 0);
    // Wrap-around from all-ones
    cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("wrap_pc", pc_atual, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);                 // wait-stated BUSCA
    reset_mid();
    cycle(1, 0, 0, 0, 0, 0);                 // stale ready during INICIO

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_mid();
      end else begin
        bit br, jp;
        br = m_started && ($urandom_range(0, 11) == 0);
        jp = m_started && ($urandom_range(0, 15) == 0);
        cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, br, jp,
              pick_target(), pick_target());
      end
    end

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
